mcb_port_model: RTL

- Synthesizable responder model of one MCB-style user port: command FIFO, write-data FIFO and read-data FIFO, backed by a single-port on-chip word memory.
- The counterpart of the team's burst master. It stands in for the DDR controller port in simulation and in DDR-less FPGA builds, so the burst master and everything upstream of it run unchanged.

---
 rtl/mcb_port_if.sv | 40 ++++
 rtl/mcb_port_model.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/mcb_port_if.sv
// MCB-style user port: command, write-data and read-data channels.
// The model drives through the slave modport; the burst master uses master.
interface mcb_port_if #(parameter int MEM_DATA_BITS = 64);
  localparam int BYTES = MEM_DATA_BITS / 8;

  logic                     calib_done;
  logic                     cmd_en;
  logic [2:0]               cmd_instr;
  logic [5:0]               cmd_bl;
  logic [29:0]              cmd_byte_addr;
  logic                     cmd_empty;
  logic                     cmd_full;
  logic                     wr_en;
  logic [BYTES-1:0]         wr_mask;
  logic [MEM_DATA_BITS-1:0] wr_data;
  logic                     wr_full;
  logic                     wr_empty;
  logic [6:0]               wr_count;
  logic                     wr_underrun;
  logic                     wr_error;
  logic                     rd_en;
  logic [MEM_DATA_BITS-1:0] rd_data;
  logic                     rd_full;
  logic                     rd_empty;
  logic [6:0]               rd_count;
  logic                     rd_overflow;
  logic                     rd_error;

  modport master (
    output cmd_en, cmd_instr, cmd_bl, cmd_byte_addr, wr_en, wr_mask, wr_data, rd_en,
    input  calib_done, cmd_empty, cmd_full, wr_full, wr_empty, wr_count, wr_underrun,
           wr_error, rd_data, rd_full, rd_empty, rd_count, rd_overflow, rd_error
  );

  modport slave (
    input  cmd_en, cmd_instr, cmd_bl, cmd_byte_addr, wr_en, wr_mask, wr_data, rd_en,
    output calib_done, cmd_empty, cmd_full, wr_full, wr_empty, wr_count, wr_underrun,
           wr_error, rd_data, rd_full, rd_empty, rd_count, rd_overflow, rd_error
  );
endinterface

// File: rtl/mcb_port_model.sv
// Responder model of one MCB user port: cmd/wr/rd FIFOs in front of a
// single-port word memory, executing bursts strictly in command order.
module mcb_port_model #(
  parameter int MEM_DATA_BITS  = 64,
  parameter int MEM_DEPTH_BITS = 10,
  parameter int CMD_FIFO_DEPTH = 4,
  parameter int CALIB_CYCLES   = 16
) (
  input  logic       mem_clk,
  input  logic       rst,
  mcb_port_if.slave  port
);
  localparam int BYTES = MEM_DATA_BITS / 8;
  localparam int BSH   = $clog2(BYTES);
  localparam int CAW   = $clog2(CMD_FIFO_DEPTH);
  localparam int CW    = $clog2(CALIB_CYCLES + 1);
  localparam int DW    = MEM_DEPTH_BITS;

  typedef struct packed {
    logic [2:0]  instr;
    logic [5:0]  bl;
    logic [29:0] addr;
  } cmd_t;

  typedef enum logic [2:0] {IDLE, WR_WAIT, WR_RUN, RD_WAIT, RD_RUN, RD_DRAIN} state_e;

  state_e state_q, state_d;
  logic [CW-1:0] cal_cnt_q, cal_cnt_d;
  logic calib_q, calib_d;
  logic [CAW-1:0] cwp_q, cwp_d, crp_q, crp_d;
  logic [CAW:0] ccnt_q, ccnt_d;
  logic cmd_empty_q, cmd_empty_d, cmd_full_q, cmd_full_d;
  logic [5:0] wwp_q, wwp_d, wrp_q, wrp_d, rwp_q, rwp_d, rrp_q, rrp_d;
  logic [6:0] wcnt_q, wcnt_d, rcnt_q, rcnt_d;
  logic wr_err_q, wr_err_d, rd_err_q, rd_err_d, rvld_q, rvld_d;
  logic [DW-1:0] idx_q, idx_d;
  logic [6:0] len_q, len_d, rem_q, rem_d;
  logic cmd_push, cmd_pop, wr_push, wr_pop, rd_push, rd_pop, mem_we, mem_rd;

  cmd_t cmd_mem [CMD_FIFO_DEPTH];
  logic [BYTES+MEM_DATA_BITS-1:0] wmem [64];
  logic [MEM_DATA_BITS-1:0] rmem [64];
  logic [MEM_DATA_BITS-1:0] mem [2**DW];
  logic [MEM_DATA_BITS-1:0] mrdata_q;
  cmd_t cmd_head;
  logic [BYTES-1:0] wmask;
  logic [MEM_DATA_BITS-1:0] wdata;
  logic unused_cmd_bits;

  assign cmd_head = cmd_mem[crp_q];
  assign {wmask, wdata} = wmem[wrp_q];
  assign unused_cmd_bits = ^{cmd_head.addr[29:DW+BSH], cmd_head.addr[BSH-1:0], cmd_head.instr[1]};

  assign cmd_push = port.cmd_en & calib_q & ~cmd_full_q;
  assign wr_push  = port.wr_en & (wcnt_q != 7'd64);
  assign rd_push  = rvld_q;
  assign rd_pop   = port.rd_en & (rcnt_q != 7'd0);

  // Calibration counter and FIFO bookkeeping
  always_comb begin
    cal_cnt_d = calib_q ? cal_cnt_q : cal_cnt_q + CW'(1);
    calib_d   = calib_q | (cal_cnt_q == CW'(CALIB_CYCLES - 1));
    cwp_d  = cmd_push ? cwp_q + CAW'(1) : cwp_q;
    crp_d  = cmd_pop  ? crp_q + CAW'(1) : crp_q;
    ccnt_d = ccnt_q;
    if (cmd_push && !cmd_pop) ccnt_d = ccnt_q + (CAW+1)'(1);
    if (!cmd_push && cmd_pop) ccnt_d = ccnt_q - (CAW+1)'(1);
    cmd_empty_d = (ccnt_d == '0);
    cmd_full_d  = (ccnt_d == (CAW+1)'(CMD_FIFO_DEPTH));
    wwp_d  = wr_push ? wwp_q + 6'd1 : wwp_q;
    wrp_d  = wr_pop  ? wrp_q + 6'd1 : wrp_q;
    wcnt_d = wcnt_q;
    if (wr_push && !wr_pop) wcnt_d = wcnt_q + 7'd1;
    if (!wr_push && wr_pop) wcnt_d = wcnt_q - 7'd1;
    rwp_d  = rd_push ? rwp_q + 6'd1 : rwp_q;
    rrp_d  = rd_pop  ? rrp_q + 6'd1 : rrp_q;
    rcnt_d = rcnt_q;
    if (rd_push && !rd_pop) rcnt_d = rcnt_q + 7'd1;
    if (!rd_push && rd_pop) rcnt_d = rcnt_q - 7'd1;
    wr_err_d = wr_err_q | (port.wr_en & (wcnt_q == 7'd64));
    rd_err_d = rd_err_q | (port.rd_en & (rcnt_q == 7'd0));
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    rem_d   = rem_q;
    cmd_pop = 1'b0;
    wr_pop  = 1'b0;
    mem_we  = 1'b0;
    mem_rd  = 1'b0;
    case (state_q)
      IDLE: if (!cmd_empty_q) begin
        cmd_pop = 1'b1;
        idx_d   = cmd_head.addr[DW+BSH-1:BSH];
        len_d   = {1'b0, cmd_head.bl} + 7'd1;
        rem_d   = len_d;
        // Codes with bit 2 set fall through as a one-cycle NOP
        if (!cmd_head.instr[2]) state_d = cmd_head.instr[0] ? RD_WAIT : WR_WAIT;
      end
      WR_WAIT: if (wcnt_q >= len_q) state_d = WR_RUN;
      WR_RUN: begin
        wr_pop = 1'b1;
        mem_we = 1'b1;
        idx_d  = idx_q + DW'(1);
        rem_d  = rem_q - 7'd1;
        if (rem_q == 7'd1) state_d = IDLE;
      end
      // Reserve room for the whole burst so the read FIFO can never overflow
      RD_WAIT: if ((7'd64 - rcnt_q) >= len_q) state_d = RD_RUN;
      RD_RUN: begin
        mem_rd = 1'b1;
        idx_d  = idx_q + DW'(1);
        rem_d  = rem_q - 7'd1;
        if (rem_q == 7'd1) state_d = RD_DRAIN;
      end
      RD_DRAIN: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    rvld_d = mem_rd;
  end

  always_ff @(posedge mem_clk) begin
    if (rst) begin
      state_q <= IDLE;   cal_cnt_q <= '0;  calib_q <= 1'b0;
      cwp_q <= '0;  crp_q <= '0;  ccnt_q <= '0;
      cmd_empty_q <= 1'b1;  cmd_full_q <= 1'b0;
      wwp_q <= '0;  wrp_q <= '0;  wcnt_q <= '0;
      rwp_q <= '0;  rrp_q <= '0;  rcnt_q <= '0;
      wr_err_q <= 1'b0;  rd_err_q <= 1'b0;  rvld_q <= 1'b0;
      idx_q <= '0;  len_q <= '0;  rem_q <= '0;
    end else begin
      state_q <= state_d;  cal_cnt_q <= cal_cnt_d;  calib_q <= calib_d;
      cwp_q <= cwp_d;  crp_q <= crp_d;  ccnt_q <= ccnt_d;
      cmd_empty_q <= cmd_empty_d;  cmd_full_q <= cmd_full_d;
      wwp_q <= wwp_d;  wrp_q <= wrp_d;  wcnt_q <= wcnt_d;
      rwp_q <= rwp_d;  rrp_q <= rrp_d;  rcnt_q <= rcnt_d;
      wr_err_q <= wr_err_d;  rd_err_q <= rd_err_d;  rvld_q <= rvld_d;
      idx_q <= idx_d;  len_q <= len_d;  rem_q <= rem_d;
    end
  end

  // Storage arrays are not reset; pointers and counts define their contents
  always_ff @(posedge mem_clk) begin
    if (cmd_push) cmd_mem[cwp_q] <= cmd_t'{port.cmd_instr, port.cmd_bl, port.cmd_byte_addr};
    if (wr_push)  wmem[wwp_q] <= {port.wr_mask, port.wr_data};
    if (rd_push)  rmem[rwp_q] <= mrdata_q;
    if (mem_we && !rst)
      for (int b = 0; b < BYTES; b++)
        if (!wmask[b]) mem[idx_q][b*8 +: 8] <= wdata[b*8 +: 8];
    if (mem_rd) mrdata_q <= mem[idx_q];
  end

  assign port.calib_done  = calib_q;
  assign port.cmd_empty   = cmd_empty_q;
  assign port.cmd_full    = cmd_full_q;
  assign port.wr_full     = (wcnt_q == 7'd64);
  assign port.wr_empty    = (wcnt_q == 7'd0);
  assign port.wr_count    = wcnt_q;
  assign port.wr_underrun = (state_q == WR_WAIT) && (wcnt_q < len_q);
  assign port.wr_error    = wr_err_q;
  assign port.rd_data     = (rcnt_q == 7'd0) ? '0 : rmem[rrp_q];
  assign port.rd_full     = (rcnt_q == 7'd64);
  assign port.rd_empty    = (rcnt_q == 7'd0);
  assign port.rd_count    = rcnt_q;
  assign port.rd_overflow = 1'b0;
  assign port.rd_error    = rd_err_q;
endmodule
